wavelet_sum_serializer: RTL and testbench

Downstream stage of the wavelet filter bank. It captures the per-filter FIR sums whenever the bank signals a completed calculation. It then emits them as a framed byte stream over a valid/ready handshake, which feeds the chip-level output port or UART/SPI bridge. Frames arriving while a previous frame is still draining are dropped and flagged.

---
 rtl/wavelet_sum_if.sv | 26 ++
 rtl/wavelet_sum_serializer.sv | 104 ++++++++++
 tb/tb_wavelet_sum_serializer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/wavelet_sum_if.sv
// wavelet_sum_if: sum capture and byte stream signals between the filter bank, the serializer and the downstream consumer.
//   i_sum/i_sum_valid : flattened per-filter sums plus their one-cycle strobe (into the serializer)
//   i_byte_ready      : consumer accepts o_byte this cycle (into the serializer)
//   o_byte/o_byte_valid : framed byte stream (out of the serializer)
//   o_busy/o_dropped/o_overrun : frame in flight, discard pulse, sticky discard flag (out of the serializer)
interface wavelet_sum_if #(
    parameter int NUM_FILTERS = 3,
    parameter int SUM_WIDTH   = 32
);
    logic [NUM_FILTERS*SUM_WIDTH-1:0] i_sum;
    logic                             i_sum_valid;
    logic                             i_byte_ready;
    logic [7:0]                       o_byte;
    logic                             o_byte_valid;
    logic                             o_busy;
    logic                             o_dropped;
    logic                             o_overrun;
    modport slave (
        input  i_sum, i_sum_valid, i_byte_ready,
        output o_byte, o_byte_valid, o_busy, o_dropped, o_overrun
    );
    modport master (
        output i_sum, i_sum_valid, i_byte_ready,
        input  o_byte, o_byte_valid, o_busy, o_dropped, o_overrun
    );
endinterface

// File: rtl/wavelet_sum_serializer.sv
// wavelet_sum_serializer: captures the filter bank sums and streams them as a HEADER-led byte frame over valid/ready.
//   clk   : rising-edge system clock
//   reset : asynchronous active-high reset, abandons any frame in flight
//   bus   : wavelet_sum_if.slave carrying the sums, the byte stream and the status flags
//   SUM_CHECKSUM_EN (macro) : when defined, appends an XOR checksum byte over HEADER and all data bytes
module wavelet_sum_serializer #(
    parameter int         NUM_FILTERS = 3,
    parameter int         SUM_WIDTH   = 32,
    parameter logic [7:0] HEADER      = 8'hA5
) (
    input logic        clk,
    input logic        reset,
    wavelet_sum_if.slave bus
);
    localparam int FW = NUM_FILTERS * SUM_WIDTH;
    localparam int NB = FW / 8;
    localparam int CW = NB > 1 ? $clog2(NB) : 1;
`ifdef SUM_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, HDR, DATA, CHK} state_t;
    logic [7:0] chk_q, chk_d;
`else
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif
    state_t        state_q, state_d;
    logic [FW-1:0] frame_q, frame_d, order;
    logic [CW-1:0] idx_q, idx_d;
    logic          drop_q, ovr_q, xfer, last, discard;
    // Filter 0 is placed at the top of the frame register so the whole stream is a plain MSB-first left shift.
    for (genvar k = 0; k < NUM_FILTERS; k++) begin : g_order
        assign order[(NUM_FILTERS-1-k)*SUM_WIDTH +: SUM_WIDTH] = bus.i_sum[k*SUM_WIDTH +: SUM_WIDTH];
    end
    assign xfer    = bus.o_byte_valid && bus.i_byte_ready;
    assign last    = idx_q == CW'(NB - 1);
    assign discard = bus.i_sum_valid && state_q != IDLE;
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        idx_d   = idx_q;
`ifdef SUM_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            IDLE: if (bus.i_sum_valid) begin
                state_d = HDR;
                frame_d = order;
                idx_d   = '0;
`ifdef SUM_CHECKSUM_EN
                chk_d   = '0;
`endif
            end
            HDR: if (xfer) begin
                state_d = DATA;
                idx_d   = '0;
`ifdef SUM_CHECKSUM_EN
                chk_d   = chk_q ^ HEADER;
`endif
            end
            DATA: if (xfer) begin
                frame_d = frame_q << 8;
                idx_d   = idx_q + CW'(1);
`ifdef SUM_CHECKSUM_EN
                chk_d   = chk_q ^ frame_q[FW-1 -: 8];
                state_d = last ? CHK : DATA;
`else
                state_d = last ? IDLE : DATA;
`endif
            end
`ifdef SUM_CHECKSUM_EN
            CHK: if (xfer) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            frame_q <= '0;
            idx_q   <= '0;
            drop_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SUM_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            drop_q  <= discard;
            ovr_q   <= ovr_q | discard;
`ifdef SUM_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end
    assign bus.o_byte_valid = state_q != IDLE;
    assign bus.o_busy       = state_q != IDLE;
    assign bus.o_dropped    = drop_q;
    assign bus.o_overrun    = ovr_q;
`ifdef SUM_CHECKSUM_EN
    assign bus.o_byte = state_q == HDR ? HEADER : state_q == DATA ? frame_q[FW-1 -: 8] : state_q == CHK ? chk_q : 8'h00;
`else
    assign bus.o_byte = state_q == HDR ? HEADER : state_q == DATA ? frame_q[FW-1 -: 8] : 8'h00;
`endif
endmodule

// File: tb/tb_wavelet_sum_serializer.sv
// tb_wavelet_sum_serializer: directed bench with a frame-queue reference model for the default build and a small 1x16-bit instance.
module tb_wavelet_sum_serializer;
`ifdef SUM_CHECKSUM_EN
    localparam int FLEN = 14;
`else
    localparam int FLEN = 13;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wavelet_sum_if #(.NUM_FILTERS(3), .SUM_WIDTH(32)) busa();
    wavelet_sum_if #(.NUM_FILTERS(1), .SUM_WIDTH(16)) busb();
    wavelet_sum_serializer #(.NUM_FILTERS(3), .SUM_WIDTH(32), .HEADER(8'hA5)) dut_a (.clk(clk), .reset(reset), .bus(busa));
    wavelet_sum_serializer #(.NUM_FILTERS(1), .SUM_WIDTH(16), .HEADER(8'hA5)) dut_b (.clk(clk), .reset(reset), .bus(busb));

    int errors = 0;
    int checks = 0;
    int drops = 0;
    int busy_a = 0;
    int busy_b = 0;
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    logic [7:0] m_q[$];
    bit m_drop = 1'b0;
    bit m_ovr = 1'b0;
    bit prev_v = 1'b0;
    bit prev_r = 1'b0;
    logic [7:0] prev_b = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_seq(input string nm, input logic [7:0] got[$], input logic [7:0] exp[$]);
        chk({nm, " length"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < got.size()) chk(nm, 32'(got[i]), 32'(exp[i]));
    endtask

    // Reference frame: header, then each filter's sum MSB first in filter order, optional XOR of everything sent.
    function automatic void load(input logic [95:0] s);
        logic [7:0] c;
        logic [7:0] b;
        m_q.delete();
        m_q.push_back(8'hA5);
        c = 8'hA5;
        for (int f = 0; f < 3; f++)
            for (int j = 0; j < 4; j++) begin
                b = 8'((s >> (f * 32 + 8 * (3 - j))) & 96'hFF);
                m_q.push_back(b);
                c ^= b;
            end
`ifdef SUM_CHECKSUM_EN
        m_q.push_back(c);
`endif
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_drop <= 1'b0;
            m_ovr <= 1'b0;
        end else begin
            m_drop <= busa.i_sum_valid && m_q.size() != 0;
            if (busa.i_sum_valid && m_q.size() != 0) m_ovr <= 1'b1;
            if (m_q.size() != 0) begin
                if (busa.i_byte_ready) void'(m_q.pop_front());
            end else if (busa.i_sum_valid) load(busa.i_sum);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("reset o_byte", 32'(busa.o_byte), 32'h0);
            chk("reset o_byte_valid", 32'(busa.o_byte_valid), 32'h0);
            chk("reset o_busy", 32'(busa.o_busy), 32'h0);
            chk("reset o_dropped", 32'(busa.o_dropped), 32'h0);
            chk("reset o_overrun", 32'(busa.o_overrun), 32'h0);
            prev_v = 1'b0;
        end else begin
            chk("o_byte_valid", 32'(busa.o_byte_valid), 32'(m_q.size() != 0));
            chk("o_busy", 32'(busa.o_busy), 32'(m_q.size() != 0));
            if (m_q.size() != 0) chk("o_byte", 32'(busa.o_byte), 32'(m_q[0]));
            chk("o_dropped", 32'(busa.o_dropped), 32'(m_drop));
            chk("o_overrun", 32'(busa.o_overrun), 32'(m_ovr));
            if (prev_v && !prev_r) chk("stall hold", 32'(busa.o_byte), 32'(prev_b));
            if (busa.o_byte_valid && busa.i_byte_ready) got_a.push_back(busa.o_byte);
            if (busa.o_dropped) drops++;
            if (busa.o_busy) busy_a++;
            if (busb.o_byte_valid && busb.i_byte_ready) got_b.push_back(busb.o_byte);
            if (busb.o_busy) busy_b++;
            prev_v = busa.o_byte_valid;
            prev_r = busa.i_byte_ready;
            prev_b = busa.o_byte;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start(input logic [95:0] s);
        busa.i_sum = s;
        busa.i_sum_valid = 1'b1;
        step();
        busa.i_sum_valid = 1'b0;
    endtask

    logic [7:0] exp1[$] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h03};
    logic [7:0] expb[$] = '{8'hA5, 8'hBE, 8'hEF};
    localparam logic [95:0] S1 = {32'h0000_0003, 32'hFFFF_FFFE, 32'h1234_5678};
    localparam logic [95:0] S2 = 96'hDEADBEEF_CAFEF00D_01020304;

    initial begin
`ifdef SUM_CHECKSUM_EN
        exp1.push_back(8'hAF);
        expb.push_back(8'hF4);
`endif
        busa.i_sum = '0;
        busa.i_sum_valid = 1'b0;
        busa.i_byte_ready = 1'b1;
        busb.i_sum = '0;
        busb.i_sum_valid = 1'b0;
        busb.i_byte_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        // single frame, ready high
        got_a.delete();
        busy_a = 0;
        frame_start(S1);
        @(negedge clk);
        chk("capture latency valid", 32'(busa.o_byte_valid), 32'h1);
        chk("capture latency header", 32'(busa.o_byte), 32'hA5);
        repeat (FLEN + 3) step();
        check_seq("frame1", got_a, exp1);
        chk("frame1 busy cycles", 32'(busy_a), 32'(FLEN));

        // backpressure with ready 1-0-0-1
        got_a.delete();
        frame_start(S1);
        for (int i = 0; i < 48; i++) begin
            busa.i_byte_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        busa.i_byte_ready = 1'b1;
        repeat (FLEN) step();
        check_seq("backpressure", got_a, exp1);

        // overrun at byte index 4
        got_a.delete();
        drops = 0;
        frame_start(S1);
        repeat (5) step();
        frame_start(S2);
        repeat (FLEN) step();
        check_seq("overrun frame", got_a, exp1);
        chk("overrun drop count", 32'(drops), 32'h1);
        chk("overrun sticky", 32'(busa.o_overrun), 32'h1);

        // pulse during the final transfer is dropped
        got_a.delete();
        frame_start(S1);
        repeat (FLEN - 1) step();
        frame_start(S2);
        repeat (4) step();
        check_seq("boundary frame", got_a, exp1);
        chk("boundary drop count", 32'(drops), 32'h2);
        chk("boundary idle after", 32'(busa.o_busy), 32'h0);

        // pulse one cycle after the final transfer is captured
        got_a.delete();
        frame_start(S1);
        repeat (FLEN) step();
        frame_start(S1);
        @(negedge clk);
        chk("recapture valid", 32'(busa.o_byte_valid), 32'h1);
        chk("recapture header", 32'(busa.o_byte), 32'hA5);
        chk("recapture not dropped", 32'(busa.o_dropped), 32'h0);
        repeat (FLEN + 2) step();
        chk("recapture two frames", 32'(got_a.size()), 32'(2 * FLEN));

        // reset mid-frame
        frame_start(S2);
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        chk("midreset valid", 32'(busa.o_byte_valid), 32'h0);
        chk("midreset busy", 32'(busa.o_busy), 32'h0);
        repeat (3) step();
        reset = 1'b0;
        repeat (6) step();
        chk("after reset idle", 32'(busa.o_byte_valid), 32'h0);

        // 1 x 16-bit instance
        got_b.delete();
        busy_b = 0;
        busb.i_sum = 16'hBEEF;
        busb.i_sum_valid = 1'b1;
        step();
        busb.i_sum_valid = 1'b0;
        repeat (8) step();
        check_seq("small frame", got_b, expb);
        chk("small frame busy cycles", 32'(busy_b), 32'(expb.size()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
